// File: rtl/wb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_if
// Bus bundle between NUM_MASTERS Wishbone masters, the round-robin arbiter
// and the shared slave port.
//   m_*   : packed per-master request fields (master i at its own slice)
//           plus the per-master ack/err returns and broadcast read data
//   s_*   : the single muxed slave-side port
//   grant_o / busy_o : arbiter status (one-hot owner, any owner)
// Modports:
//   slave  : the arbiter's view (it serves the masters and drives the slave)
//   master : the environment's view (masters plus the slave model)
// ---------------------------------------------------------------------------
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0]    m_cyc_i;
    logic [NUM_MASTERS-1:0]    m_stb_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [32*NUM_MASTERS-1:0] m_adr_i;
    logic [32*NUM_MASTERS-1:0] m_dat_i;
    logic [4*NUM_MASTERS-1:0]  m_sel_i;
    logic [31:0]               m_dat_o;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    logic                      s_cyc_o;
    logic                      s_stb_o;
    logic                      s_we_o;
    logic [31:0]               s_adr_o;
    logic [31:0]               s_dat_o;
    logic [3:0]                s_sel_o;
    logic [31:0]               s_dat_i;
    logic                      s_ack_i;
    logic [NUM_MASTERS-1:0]    grant_o;
    logic                      busy_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output grant_o, busy_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// A grant is held for the owner's whole cycle (cyc high); on release the
// next requester after the previous owner wins at the same edge. A watchdog
// aborts any strobed transfer left un-acked for TIMEOUT cycles with a
// single-cycle err to the owner (grant kept, slave sees cyc/stb low).
// Ports:
//   sys_clk : clock, rising edge
//   sys_rst : synchronous active-high reset
//   bus     : wb_rr_arbiter_if.slave (master requests, slave port, status)
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    wb_rr_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT_0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [NUM_MASTERS-1:0] NO_GRANT  = {NUM_MASTERS{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [NUM_MASTERS-1:0] grant_r, grant_nxt_s;
    logic [IDX_W-1:0]       last_r, last_nxt_s;
    logic [15:0]            wdog_r, wdog_nxt_s;
    logic                   abort_r, abort_nxt_s;

    logic                   found_s;
    logic [IDX_W-1:0]       pick_s;
    logic                   owner_cyc_s;
    logic                   owner_stb_s;
    logic                   owner_req_s;
    logic                   owner_we_s;
    logic                   grant_chg_s;
    logic                   timeout_hit_s;
    logic [31:0]            mux_adr_s;
    logic [31:0]            mux_dat_s;
    logic [3:0]             mux_sel_s;

    // Round-robin scan: first cyc requester after the previous owner, wrapping.
    // The previous owner is visited last, so a releasing master has lowest priority.
    always_comb begin
        int idx_v;
        idx_v   = 0;
        found_s = 1'b0;
        pick_s  = last_r;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx_v = (int'(last_r) + k) % NUM_MASTERS;
            if (!found_s && bus.m_cyc_i[idx_v]) begin
                found_s = 1'b1;
                pick_s  = IDX_W'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Owner's control bits and one-hot AND-OR mux of the owner's fields (zero when idle).
    always_comb begin
        owner_cyc_s = |(grant_r & bus.m_cyc_i);
        owner_stb_s = |(grant_r & bus.m_stb_i);
        owner_req_s = |(grant_r & bus.m_cyc_i & bus.m_stb_i);
        owner_we_s  = |(grant_r & bus.m_we_i);
        mux_adr_s   = 32'h0;
        mux_dat_s   = 32'h0;
        mux_sel_s   = 4'h0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            mux_adr_s = mux_adr_s | (bus.m_adr_i[32*i +: 32] & {32{grant_r[i]}});
            mux_dat_s = mux_dat_s | (bus.m_dat_i[32*i +: 32] & {32{grant_r[i]}});
            mux_sel_s = mux_sel_s | (bus.m_sel_i[4*i +: 4]   & {4{grant_r[i]}});
        end
    end

    // Grant FSM next state: grant from idle, hold while owner cyc is high,
    // re-arbitrate in the same edge as the release.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        last_nxt_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ST_OWN;
                    grant_nxt_s = ONE_HOT_0 << pick_s;
                    last_nxt_s  = pick_s;
                end else begin
                    grant_nxt_s = NO_GRANT;
                end
            end
            ST_OWN: begin
                if (owner_cyc_s) begin
                    grant_nxt_s = grant_r;
                end else if (found_s) begin
                    grant_nxt_s = ONE_HOT_0 << pick_s;
                    last_nxt_s  = pick_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = NO_GRANT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = NO_GRANT;
            end
        endcase
    end

    // Watchdog: count un-acked strobed cycles; an ack in the last cycle beats the timeout.
    // The abort is dropped if the grant moves at that edge, so it never hits a new owner.
    always_comb begin
        grant_chg_s   = (grant_nxt_s != grant_r);
        timeout_hit_s = owner_req_s & ~bus.s_ack_i & ~abort_r & (wdog_r == WDOG_LAST);
        abort_nxt_s   = timeout_hit_s & ~grant_chg_s;
        if (abort_r || grant_chg_s || !owner_req_s || bus.s_ack_i || timeout_hit_s) begin
            wdog_nxt_s = 16'h0;
        end else begin
            wdog_nxt_s = wdog_r + 16'h1;
        end
    end

    // State registers with synchronous reset; master 0 gets first priority after reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            grant_r <= NO_GRANT;
            last_r  <= IDX_W'(NUM_MASTERS - 1);
            wdog_r  <= 16'h0;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            last_r  <= last_nxt_s;
            wdog_r  <= wdog_nxt_s;
            abort_r <= abort_nxt_s;
        end
    end

    // Output datapath from the registered grant; the abort cycle masks slave controls and ack.
    assign bus.grant_o = grant_r;
    assign bus.busy_o  = |grant_r;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = grant_r & bus.m_stb_i & {NUM_MASTERS{bus.s_ack_i & ~abort_r}};
    assign bus.m_err_o = grant_r & {NUM_MASTERS{abort_r}};
    assign bus.s_cyc_o = owner_cyc_s & ~abort_r;
    assign bus.s_stb_o = owner_stb_s & ~abort_r;
    assign bus.s_we_o  = owner_we_s;
    assign bus.s_adr_o = mux_adr_s;
    assign bus.s_dat_o = mux_dat_s;
    assign bus.s_sel_o = mux_sel_s;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Directed bench for wb_rr_arbiter (4 masters, TIMEOUT=8). Inputs change
// 1 time unit after each rising edge; outputs are compared 1 unit later.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;
    localparam int NM = 4;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_vec   = 0;
    int   n_err   = 0;

    wb_rr_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    wb_rr_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(8)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.m_cyc_i = 4'b0000;
        bus.m_stb_i = 4'b0000;
        bus.s_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
    endtask

    // Masters in req each do one transfer, drop cyc for one cycle, then re-request.
    task automatic rr_seq(input logic [3:0] req, input int exp_q[6], input int n);
        int          prev;
        logic [3:0]  exp_g;
        logic [31:0] exp_adr;
        prev = -1;
        bus.m_cyc_i = req;
        bus.m_stb_i = req;
        for (int j = 0; j < n; j++) begin
            tick();
            if (prev >= 0) begin
                bus.m_cyc_i[prev] = 1'b1;
                bus.m_stb_i[prev] = 1'b1;
            end
            exp_g   = 4'b0001 << exp_q[j];
            exp_adr = 32'h1000_0000 + 32'(exp_q[j]) * 32'h10;
            #1;
            check_eq("rr_grant", {28'h0, bus.grant_o}, {28'h0, exp_g});
            check_eq("rr_adr", bus.s_adr_o, exp_adr);
            bus.s_ack_i = 1'b1;
            #1;
            check_eq("rr_ack", {28'h0, bus.m_ack_o}, {28'h0, exp_g});
            tick();
            bus.m_cyc_i[exp_q[j]] = 1'b0;
            bus.m_stb_i[exp_q[j]] = 1'b0;
            bus.s_ack_i = 1'b0;
            #1;
            check_eq("rr_hold", {28'h0, bus.grant_o}, {28'h0, exp_g});
            check_eq("rr_busy", {31'h0, bus.busy_o}, 32'h1);
            prev = exp_q[j];
        end
    endtask

    initial begin
        bus.m_we_i  = 4'b1010;
        bus.s_dat_i = 32'hCAFE_F00D;
        for (int i = 0; i < NM; i++) begin
            bus.m_adr_i[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h10;
            bus.m_dat_i[32*i +: 32] = 32'hD000_0000 + 32'(i);
            bus.m_sel_i[4*i +: 4]   = 4'(i + 1);
        end
        clear_reqs();
        tick();
        do_reset();

        // Reset state
        check_eq("rst_grant", {28'h0, bus.grant_o}, 32'h0);
        check_eq("rst_busy",  {31'h0, bus.busy_o}, 32'h0);
        check_eq("rst_scyc",  {31'h0, bus.s_cyc_o}, 32'h0);
        check_eq("rst_adr",   bus.s_adr_o, 32'h0);
        check_eq("rd_bcast",  bus.m_dat_o, 32'hCAFE_F00D);

        // stb without cyc is ignored
        bus.m_stb_i = 4'b0010;
        bus.s_ack_i = 1'b1;
        tick();
        check_eq("stb_only_grant", {28'h0, bus.grant_o}, 32'h0);
        check_eq("stb_only_ack",   {28'h0, bus.m_ack_o}, 32'h0);
        clear_reqs();

        // Masters 0 and 2 alternate: 0,2,0,2 with no idle cycle
        rr_seq(4'b0101, '{0, 2, 0, 2, 0, 0}, 4);
        clear_reqs();
        tick();
        check_eq("rr_idle", {28'h0, bus.grant_o}, 32'h0);

        // All four request: 0,1,2,3,0,1 wrapping
        do_reset();
        rr_seq(4'b1111, '{0, 1, 2, 3, 0, 1}, 6);

        // Master 1 holds cyc over 3 transfers while master 3 waits
        do_reset();
        bus.m_cyc_i = 4'b0010;
        bus.m_stb_i = 4'b0010;
        tick();
        bus.m_cyc_i[3] = 1'b1;
        bus.m_stb_i[3] = 1'b1;
        #1;
        check_eq("hold_grant", {28'h0, bus.grant_o}, 32'h2);
        check_eq("hold_sel",   {28'h0, bus.s_sel_o}, 32'h2);
        check_eq("hold_we",    {31'h0, bus.s_we_o}, 32'h1);
        check_eq("hold_dat",   bus.s_dat_o, 32'hD000_0001);
        for (int t = 0; t < 3; t++) begin
            bus.s_ack_i = 1'b1;
            #1;
            check_eq("hold_ack", {28'h0, bus.m_ack_o}, 32'h2);
            tick();
            check_eq("hold_grant_t", {28'h0, bus.grant_o}, 32'h2);
        end
        bus.s_ack_i    = 1'b0;
        bus.m_cyc_i[1] = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        #1;
        check_eq("hold_rel_same", {28'h0, bus.grant_o}, 32'h2);
        tick();
        check_eq("hold_next", {28'h0, bus.grant_o}, 32'h8);

        // Timeout: master 2 strobes, slave never acks -> err 8 cycles after stb
        do_reset();
        bus.m_cyc_i = 4'b0100;
        tick();
        check_eq("to_grant", {28'h0, bus.grant_o}, 32'h4);
        bus.m_stb_i = 4'b0100;
        #1;
        check_eq("to_stb0", {31'h0, bus.s_stb_o}, 32'h1);
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_eq("to_no_err", {28'h0, bus.m_err_o}, 32'h0);
        end
        tick();
        check_eq("to_err",   {28'h0, bus.m_err_o}, 32'h4);
        check_eq("to_sstb",  {31'h0, bus.s_stb_o}, 32'h0);
        check_eq("to_scyc",  {31'h0, bus.s_cyc_o}, 32'h0);
        check_eq("to_grant_kept", {28'h0, bus.grant_o}, 32'h4);
        bus.s_ack_i = 1'b1;
        #1;
        check_eq("to_ack_ignored", {28'h0, bus.m_ack_o}, 32'h0);
        check_eq("to_err_still",   {28'h0, bus.m_err_o}, 32'h4);
        bus.s_ack_i = 1'b0;
        tick();
        check_eq("to_err_once", {28'h0, bus.m_err_o}, 32'h0);
        check_eq("to_sstb_back", {31'h0, bus.s_stb_o}, 32'h1);

        // Ack in the last watchdog cycle wins, and the count restarts from 0
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_eq("lastack_wait", {28'h0, bus.m_err_o}, 32'h0);
        end
        bus.s_ack_i = 1'b1;
        #1;
        check_eq("lastack_ack", {28'h0, bus.m_ack_o}, 32'h4);
        tick();
        bus.s_ack_i = 1'b0;
        #1;
        check_eq("lastack_no_err", {28'h0, bus.m_err_o}, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_eq("restart_wait", {28'h0, bus.m_err_o}, 32'h0);
        end
        tick();
        check_eq("restart_err", {28'h0, bus.m_err_o}, 32'h4);

        // Reset while master 0 owns with stb high; priority pointer returns to 3
        do_reset();
        bus.m_cyc_i = 4'b0001;
        bus.m_stb_i = 4'b0001;
        tick();
        check_eq("mrst_grant", {28'h0, bus.grant_o}, 32'h1);
        sys_rst = 1'b1;
        tick();
        bus.s_ack_i = 1'b1;
        #1;
        check_eq("mrst_grant0", {28'h0, bus.grant_o}, 32'h0);
        check_eq("mrst_scyc",   {31'h0, bus.s_cyc_o}, 32'h0);
        check_eq("mrst_ack",    {28'h0, bus.m_ack_o}, 32'h0);
        check_eq("mrst_err",    {28'h0, bus.m_err_o}, 32'h0);
        sys_rst     = 1'b0;
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i = 4'b1001;
        bus.m_stb_i = 4'b1001;
        tick();
        check_eq("mrst_regrant", {28'h0, bus.grant_o}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
